// File: rtl/tdp_ram_arb_pkg.sv
// Shared types and round-robin pick function
// for the RAM port arbiter.
package tdp_ram_arb_pkg;

  localparam int AW     = 4;
  localparam int DW     = 4;
  localparam int MAXREQ = 8;
  localparam int PTRW   = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              vld;
    logic [MAXREQ-1:0] id;
  } tag_t;

  // First valid bit at or after ptr, wrapping modulo n.
  function automatic logic [MAXREQ-1:0] rr_pick(
    input logic [MAXREQ-1:0] valid,
    input logic [PTRW-1:0]   ptr,
    input int                n
  );
    logic [MAXREQ-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && g == '0 && valid[idx])
        g[idx] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/tdp_ram_arb_rr_arbiter.sv
// Round-robin grant logic with the
// rotating priority pointer.
module rr_arbiter
  import tdp_ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr
);

  logic [MAXREQ-1:0] vx;
  logic [MAXREQ-1:0] gx;
  logic [PW-1:0]     nxt;
  logic              unused_g;

  assign vx       = MAXREQ'(valid);
  assign gx       = rr_pick(vx, PTRW'(ptr), NREQ);
  assign unused_g = ^gx;
  assign grant    = rst_n ? gx[NREQ-1:0] : '0;

  always_comb begin
    nxt = ptr;
    for (int i = 0; i < NREQ; i++)
      if (grant[i])
        nxt = (i == NREQ-1) ? '0 : PW'(i+1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance)
      ptr <= nxt;
  end

endmodule

// File: rtl/tdp_ram_arb.sv
// Shares one registered read-first RAM port
// among NREQ requesters with tagged responses.
module tdp_ram_arb
  import tdp_ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  logic [NREQ-1:0]         grant;
  logic [$clog2(NREQ)-1:0] unused_ptr;
  logic                    xfer;
  req_t                    sel;
  tag_t                    tag1;
  tag_t                    tag2;
  logic                    unused_tag;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (xfer),
    .grant   (grant),
    .ptr     (unused_ptr)
  );

  assign req_ready  = grant;
  assign xfer       = |grant;
  assign unused_tag = ^tag2;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        sel.we    = req_we[i];
        sel.addr  = req_addr[i*AW +: AW];
        sel.wdata = req_wdata[i*DW +: DW];
      end
  end

  // Idle cycles drop ram_we but keep the
  // address, so the RAM does a harmless read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else if (xfer) begin
      ram_we   <= sel.we;
      ram_addr <= sel.addr;
      ram_din  <= sel.wdata;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1      <= '0;
      tag2      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      tag1      <= '{vld: xfer, id: MAXREQ'(grant)};
      tag2      <= tag1;
      rsp_valid <= tag2.vld ? tag2.id[NREQ-1:0] : '0;
      rsp_rdata <= ram_dout;
    end
  end

endmodule

// File: doc/tdp_ram_arb.md
# tdp_ram_arb

Round-robin arbiter that shares one port of the read-first dual-port RAM (`tdp_ram_rf`) between NREQ requesters on a single clock. It does the following:
- accepts one read or write per cycle through a valid/ready handshake;
- drives the registered RAM port;
- routes the RAM read data back to the originating requester as a tagged response.

It sits between the client engines and port A (or B) of the RAM.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 4, RAM address width
- DW, 4, RAM data width

Ports:
- clk  in  1  single clock for the block and the attached RAM port
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_we  in  NREQ  per-requester write enable (1 = write, 0 = read)
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; at most one bit is high per cycle
- rsp_valid  out  NREQ  one-hot response strobe to the originating requester
- rsp_rdata  out  DW  response data, shared by all requesters; qualified by rsp_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data (read-first, 1-cycle registered read)

## Operation
- **Grant:**
  - req_ready is a combinational function of req_valid and the priority pointer ptr.
  - The winner is the first requester with valid set, searching ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready[i] is never high unless req_valid[i] is high.
- **Handshake:**
  - A transfer occurs on an edge where req_valid[i] & req_ready[i].
  - A requester must hold valid, we, addr and wdata stable until it is accepted.
  - Deasserting valid before acceptance is permitted: the request is withdrawn and no response follows.
- **Pointer:**
  - On each transfer to requester g, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr holds.
  - ptr resets to 0.
  - A continuously requesting client therefore waits at most NREQ-1 grants.
- **Issue stage (registered):**
  - On a transfer, ram_we <= req_we[g], ram_addr <= addr[g], ram_din <= wdata[g].
  - With no transfer, ram_we <= 0 and ram_addr/ram_din hold their values. The idle cycle performs a harmless read.
- **Response:**
  - Every accepted request, read or write, produces exactly one response.
  - Reads return the addressed content.
  - Writes return the pre-write content (read-first), which also serves as the write acknowledge.
  - A tag pipeline (one-hot ID plus valid, two stages) tracks ownership. rsp_valid <= tag stage 2 and rsp_rdata <= ram_dout, both registered.
- **Hazards:**
  - A write followed by a read of the same address on the next transfer returns the new data; the RAM writes before the following read.
  - No reordering is possible; responses return in acceptance order.
- **Reset values:** req_ready = 0 (combinational; valid is ignored while rst_n is low), rsp_valid = 0, rsp_rdata = 0, ram_we = 0, ram_addr = 0, ram_din = 0, ptr = 0, all tag valids 0.
- **Reset mid-operation:** all in-flight tags are discarded and no response is emitted for them. A write already registered on ram_we is cancelled if reset arrives before the RAM edge.

## Timing
- Transfer at edge E0, then:
  - ram_* valid during cycle E0→E1;
  - RAM samples at E1;
  - rsp_valid/rsp_rdata valid during cycle E2→E3.
- Request-to-response latency is 2 clocks.
- Throughput is one transfer per clock, sustained, with any mix of requesters.
- Back-to-back responses are allowed; rsp_valid may stay high for consecutive cycles with different one-hot owners.
- A single requester holding valid with no competition is granted every cycle.

## Structure
- Package tdp_ram_arb_pkg holds:
  - the request struct typedef {we, addr, wdata}, parameterised through package localparams AW/DW;
  - the tag typedef {vld, id one-hot};
  - a function rr_pick(valid, ptr) that returns a one-hot grant.
- Sub-module rr_arbiter holds the ptr register and the grant logic (valid, advance → grant, ptr). The top contains the issue registers, tag pipeline and response registers.

## Test plan
- **Reset values:** assert rst_n low with all req_valid high → req_ready=0, rsp_valid=0, ram_we=0. Release rst_n → first grant goes to requester 0.
- **Fairness:** all 4 requesters issue continuous reads → grants 0,1,2,3,0,1… every cycle, and 16 rsp_valid pulses arrive in the same order with 2-cycle latency.
- **Read-first write acknowledge:** req0 writes 0xA to addr 3, then req1 reads addr 3 on the next cycle → req0 response carries the old content, req1 response carries 0xA.
- **Pointer wrap and holding:** only req2 and req3 valid, with req3 held → grants alternate 2,3,2,3. When req2 drops, req3 is granted every cycle.
- **Withdraw:** req1 raises valid while req0 holds the grant, then drops it before acceptance → no transfer and no rsp_valid[1].
- **Reset mid-flight:** reset pulses one cycle after two reads are accepted → no rsp_valid after reset release, and ptr=0.
